alu_issue_stage: RTL and testbench

- ID/EX pipeline stage that drives the ALU's operand/opcode interface (a, b, 3-bit opcode).
- Decodes RV32I OP and OP-IMM instructions into the ALU's 3-bit opcode encoding.
- Selects operand b from rs2 or the sign-extended immediate.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered.

---
 rtl/alu_issue_stage_if.sv | 27 ++
 rtl/alu_issue_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction/operand handshake and the ALU-facing issue handshake.
// master = environment side (decode/regfile and execute), slave = the issue stage itself.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_opcode;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;

  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_opcode, rd_addr, rd_we, illegal
  );

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_opcode, rd_addr, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decode into ALU issue bundle; 1-cycle latency, 1/cycle throughput.
// Output reg + skid reg behind valid/ready; in_ready is a register (!skid_valid).
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_stage_if.slave bus,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRL  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } issue_t;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm;
  logic        w_legal;
  logic [2:0]  w_op;
  logic [31:0] w_b;
  issue_t      w_dec;
  logic        w_unused_rs1;

  assign w_opc        = bus.instr[6:0];
  assign w_f3         = bus.instr[14:12];
  assign w_f7         = bus.instr[31:25];
  assign w_imm        = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign w_unused_rs1 = ^bus.instr[19:15];

  always_comb begin
    w_legal = 1'b0;
    w_op    = ALU_ADD;
    w_b     = bus.rs2_data;
    case (w_opc)
      7'b0110011: begin
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
          case (w_f3)
            3'b000:  w_op = ALU_ADD;
            3'b001:  w_op = ALU_SLL;
            3'b011:  w_op = ALU_SLTU;
            3'b100:  w_op = ALU_XOR;
            3'b101:  w_op = ALU_SRL;
            3'b110:  w_op = ALU_OR;
            3'b111:  w_op = ALU_AND;
            default: w_legal = 1'b0;   // signed SLT has no ALU encoding
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_legal = 1'b1;
          w_op    = ALU_SUB;
        end
      end
      7'b0010011: begin
        w_b     = w_imm;
        w_legal = 1'b1;
        case (w_f3)
          3'b000:  w_op = ALU_ADD;
          3'b011:  w_op = ALU_SLTU;
          3'b100:  w_op = ALU_XOR;
          3'b110:  w_op = ALU_OR;
          3'b111:  w_op = ALU_AND;
          3'b001: begin
            w_op    = ALU_SLL;
            w_b     = {27'b0, bus.instr[24:20]};
            w_legal = (w_f7 == 7'b0000000);
          end
          3'b101: begin
            w_op    = ALU_SRL;
            w_b     = {27'b0, bus.instr[24:20]};
            w_legal = (w_f7 == 7'b0000000);
          end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_op = ALU_ADD;
    end
    w_dec.a   = bus.rs1_data;
    w_dec.b   = w_b;
    w_dec.op  = w_op;
    w_dec.rd  = bus.instr[11:7];
    w_dec.we  = w_legal && (bus.instr[11:7] != 5'd0);
    w_dec.ill = !w_legal;
  end

  issue_t           r_out;
  logic             r_out_vld;
  issue_t           r_skd;
  logic             r_skd_vld;
  logic [CNT_W-1:0] r_iss_cnt;
  logic [CNT_W-1:0] r_ill_cnt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_out_free;

  assign w_in_xfer  = bus.in_valid & ~r_skd_vld;
  assign w_out_xfer = r_out_vld & bus.out_ready;
  assign w_out_free = ~r_out_vld | w_out_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_skd     <= '0;
      r_skd_vld <= 1'b0;
    end else if (flush) begin
      r_out_vld <= 1'b0;
      r_skd_vld <= 1'b0;
    end else if (w_out_free) begin
      // skid always holds the older entry, so it drains before new input
      if (r_skd_vld) begin
        r_out     <= r_skd;
        r_out_vld <= 1'b1;
        r_skd_vld <= 1'b0;
      end else if (w_in_xfer) begin
        r_out     <= w_dec;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skd     <= w_dec;
      r_skd_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_cnt <= '0;
      r_ill_cnt <= '0;
    end else if (w_out_xfer) begin
      if (~&r_iss_cnt) begin
        r_iss_cnt <= r_iss_cnt + CNT_W'(1);
      end
      if (r_out.ill && ~&r_ill_cnt) begin
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = ~r_skd_vld;
  assign bus.out_valid  = r_out_vld;
  assign bus.alu_a      = r_out.a;
  assign bus.alu_b      = r_out.b;
  assign bus.alu_opcode = r_out.op;
  assign bus.rd_addr    = r_out.rd;
  assign bus.rd_we      = r_out.we;
  assign bus.illegal    = r_out.ill;
  assign issue_cnt      = r_iss_cnt;
  assign illegal_cnt    = r_ill_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with 4-bit counters so saturation is reachable.
module tb_alu_issue_stage;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] illegal_cnt;
  int               checks;
  int               failures;
  int               exp_iss;
  int               exp_ill;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .issue_cnt   (issue_cnt),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] it(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, ".issue_cnt"}, 32'(issue_cnt), sat(exp_iss));
    chk({tag, ".illegal_cnt"}, 32'(illegal_cnt), sat(exp_ill));
  endtask

  // One instruction through an idle stage with out_ready high, then consumed.
  task automatic dec_chk(input string tag, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op, input logic [31:0] eb,
                         input logic [4:0] rd, input logic we, input logic ill);
    bus.instr     = ins;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 1);
    chk({tag, ".alu_a"}, bus.alu_a, a);
    if (!ill) chk({tag, ".alu_b"}, bus.alu_b, eb);
    chk({tag, ".opcode"}, 32'(bus.alu_opcode), 32'(op));
    chk({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'(rd));
    chk({tag, ".rd_we"}, 32'(bus.rd_we), 32'(we));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    tick();
    exp_iss++;
    if (ill) exp_ill++;
    chk({tag, ".drained"}, 32'(bus.out_valid), 0);
    chk_cnt(tag);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, ".alu_a"}, bus.alu_a, 0);
    chk({tag, ".alu_b"}, bus.alu_b, 0);
    chk({tag, ".opcode"}, 32'(bus.alu_opcode), 0);
    chk({tag, ".rd_addr"}, 32'(bus.rd_addr), 0);
    chk({tag, ".rd_we"}, 32'(bus.rd_we), 0);
    chk({tag, ".illegal"}, 32'(bus.illegal), 0);
    chk({tag, ".issue_cnt"}, 32'(issue_cnt), 0);
    chk({tag, ".illegal_cnt"}, 32'(illegal_cnt), 0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_iss       = 0;
    exp_ill       = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.rs1_data  = 32'h0;
    bus.rs2_data  = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();

    dec_chk("add", 32'h002081B3, 32'd5, 32'd7, 3'b000, 32'd7, 5'd3, 1'b1, 1'b0);

    // SUB then ADDI back-to-back with out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h402082B3;
    bus.rs1_data  = 32'd100;
    bus.rs2_data  = 32'd30;
    tick();
    chk("b2b.sub.vld", 32'(bus.out_valid), 1);
    chk("b2b.sub.op", 32'(bus.alu_opcode), 32'b001);
    chk("b2b.sub.rd", 32'(bus.rd_addr), 5);
    bus.instr    = 32'hFFF00093;
    bus.rs1_data = 32'd9;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b.addi.vld", 32'(bus.out_valid), 1);
    chk("b2b.addi.op", 32'(bus.alu_opcode), 32'b000);
    chk("b2b.addi.b", bus.alu_b, 32'hFFFFFFFF);
    chk("b2b.addi.rd", 32'(bus.rd_addr), 1);
    chk("b2b.mid.cnt", 32'(issue_cnt), 2);
    tick();
    exp_iss += 2;
    chk("b2b.end.vld", 32'(bus.out_valid), 0);
    chk_cnt("b2b");

    // Backpressure: three instructions offered while out_ready is low
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = rt(7'd0, 3'b000, 5'd22);
    bus.rs1_data  = 32'h11;
    tick();
    chk("bp.e1.rd", 32'(bus.rd_addr), 22);
    chk("bp.e1.rdy", 32'(bus.in_ready), 1);
    bus.instr    = rt(7'd0, 3'b000, 5'd23);
    bus.rs1_data = 32'h22;
    tick();
    chk("bp.e2.rd", 32'(bus.rd_addr), 22);
    chk("bp.e2.a", bus.alu_a, 32'h11);
    chk("bp.e2.rdy", 32'(bus.in_ready), 0);
    bus.instr    = rt(7'd0, 3'b000, 5'd24);
    bus.rs1_data = 32'h33;
    tick();
    chk("bp.e3.rd", 32'(bus.rd_addr), 22);
    chk("bp.e3.rdy", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp.e4.rd", 32'(bus.rd_addr), 23);
    chk("bp.e4.a", bus.alu_a, 32'h22);
    chk("bp.e4.rdy", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp.e5.rd", 32'(bus.rd_addr), 24);
    chk("bp.e5.a", bus.alu_a, 32'h33);
    tick();
    exp_iss += 3;
    chk("bp.e6.vld", 32'(bus.out_valid), 0);
    chk_cnt("bp");

    // Flush with both entries full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = rt(7'd0, 3'b000, 5'd25);
    tick();
    bus.instr = rt(7'd0, 3'b000, 5'd26);
    tick();
    bus.in_valid = 1'b0;
    chk("fl.full.rdy", 32'(bus.in_ready), 0);
    chk("fl.full.vld", 32'(bus.out_valid), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.vld", 32'(bus.out_valid), 0);
    chk("fl.rdy", 32'(bus.in_ready), 1);
    chk_cnt("fl");
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl.drop.vld", 32'(bus.out_valid), 0);
    tick();
    chk("fl.drop.vld2", 32'(bus.out_valid), 0);
    chk("fl.drop.rdy", 32'(bus.in_ready), 1);

    // Decode coverage; also pushes issue_cnt into saturation
    dec_chk("and",   rt(7'd0, 3'b111, 5'd4),  32'h1234, 32'hA5A5, 3'b010, 32'hA5A5, 5'd4, 1'b1, 1'b0);
    dec_chk("or",    rt(7'd0, 3'b110, 5'd6),  32'h1, 32'h2, 3'b011, 32'h2, 5'd6, 1'b1, 1'b0);
    dec_chk("xor",   rt(7'd0, 3'b100, 5'd7),  32'h3, 32'h4, 3'b100, 32'h4, 5'd7, 1'b1, 1'b0);
    dec_chk("sll",   rt(7'd0, 3'b001, 5'd8),  32'h5, 32'h6, 3'b101, 32'h6, 5'd8, 1'b1, 1'b0);
    dec_chk("srl",   rt(7'd0, 3'b101, 5'd9),  32'h7, 32'h8, 3'b110, 32'h8, 5'd9, 1'b1, 1'b0);
    dec_chk("sltu",  rt(7'd0, 3'b011, 5'd10), 32'h9, 32'hA, 3'b111, 32'hA, 5'd10, 1'b1, 1'b0);
    dec_chk("slt",   rt(7'd0, 3'b010, 5'd11), 32'hB, 32'hC, 3'b000, 32'h0, 5'd11, 1'b0, 1'b1);
    dec_chk("sra",   rt(7'h20, 3'b101, 5'd12), 32'hD, 32'hE, 3'b000, 32'h0, 5'd12, 1'b0, 1'b1);
    dec_chk("mul",   rt(7'h01, 3'b000, 5'd13), 32'hF, 32'h10, 3'b000, 32'h0, 5'd13, 1'b0, 1'b1);
    dec_chk("add.x0", rt(7'd0, 3'b000, 5'd0), 32'h11, 32'h12, 3'b000, 32'h12, 5'd0, 1'b0, 1'b0);
    dec_chk("andi",  it(12'h800, 3'b111, 5'd14), 32'h13, 32'h14, 3'b010, 32'hFFFFF800, 5'd14, 1'b1, 1'b0);
    dec_chk("ori",   it(12'h123, 3'b110, 5'd15), 32'h15, 32'h16, 3'b011, 32'h00000123, 5'd15, 1'b1, 1'b0);
    dec_chk("xori",  it(12'h7FF, 3'b100, 5'd16), 32'h17, 32'h18, 3'b100, 32'h000007FF, 5'd16, 1'b1, 1'b0);
    dec_chk("sltiu", it(12'hFFE, 3'b011, 5'd17), 32'h19, 32'h1A, 3'b111, 32'hFFFFFFFE, 5'd17, 1'b1, 1'b0);
    dec_chk("slti",  it(12'h005, 3'b010, 5'd18), 32'h1B, 32'h1C, 3'b000, 32'h0, 5'd18, 1'b0, 1'b1);
    dec_chk("slli",  it(12'h01F, 3'b001, 5'd19), 32'h1D, 32'h1E, 3'b101, 32'd31, 5'd19, 1'b1, 1'b0);
    dec_chk("srli",  it(12'h004, 3'b101, 5'd20), 32'h1F, 32'h20, 3'b110, 32'd4, 5'd20, 1'b1, 1'b0);
    dec_chk("srai",  32'h4030D093, 32'h21, 32'h22, 3'b000, 32'h0, 5'd1, 1'b0, 1'b1);
    dec_chk("slli.f7", it(12'h023, 3'b001, 5'd21), 32'h23, 32'h24, 3'b000, 32'h0, 5'd21, 1'b0, 1'b1);
    dec_chk("lui",   32'h123450B7, 32'h25, 32'h26, 3'b000, 32'h0, 5'd1, 1'b0, 1'b1);

    // Asynchronous reset with both entries full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = rt(7'd0, 3'b111, 5'd27);
    bus.rs1_data  = 32'hDEADBEEF;
    bus.rs2_data  = 32'hCAFEF00D;
    tick();
    bus.instr = rt(7'd0, 3'b110, 5'd28);
    tick();
    bus.in_valid = 1'b0;
    chk("ar.pre.rdy", 32'(bus.in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("ar");
    exp_iss = 0;
    exp_ill = 0;
    tick();
    rst_n = 1'b1;
    tick();
    dec_chk("post.add", 32'h002081B3, 32'd1, 32'd2, 3'b000, 32'd2, 5'd3, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
